// File: rtl/mux4_rr_scheduler_if.sv
// Bus between the round-robin scheduler and its requesters.
// The scheduler side uses the slave modport; requesters/bench use master.
interface mux4_rr_scheduler_if;
    logic [3:0] req;
    logic [3:0] din;
    logic       lock;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       y;
    logic       busy;
    logic       done;

    modport master (
        output req, din, lock,
        input  sel, gnt, y, busy, done
    );

    modport slave (
        input  req, din, lock,
        output sel, gnt, y, busy, done
    );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 bit mux among four requesters.
// Each grant is held for DWELL_CYCLES, or longer while lock is high.
module mux4_rr_scheduler #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input logic                clk,
    input logic                rst,
    mux4_rr_scheduler_if.slave bus
);

    localparam logic [0:0]       IDLE   = 1'b0;
    localparam logic [0:0]       GRANT  = 1'b1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [0:0]       state;
    logic [1:0]       sel;
    logic [1:0]       last;
    logic [3:0]       gnt;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    logic             end_grant;
    logic             found;
    logic [1:0]       ptr;
    logic [1:0]       winner;

    // Scan last+1 .. last+4 (mod 4); the previous holder comes last but stays eligible.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
        logic       hit;
        logic [1:0] idx;
        logic [1:0] cand;
        hit = 1'b0;
        idx = p;
        for (int i = 1; i <= 4; i++) begin
            cand = p + 2'(i);
            if (!hit && r[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
        return {hit, idx};
    endfunction

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        end_grant       = !bus.req[sel] || (cnt == '0 && !bus.lock);
        ptr             = (state == GRANT && end_grant) ? sel : last;
        {found, winner} = arbitrate(bus.req, ptr);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            last  <= 2'd3;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE || end_grant) begin
                // Ending a grant advances the pointer and re-arbitrates in the same edge.
                if (state == GRANT) begin
                    done <= 1'b1;
                    last <= sel;
                end
                if (found) begin
                    state <= GRANT;
                    sel   <= winner;
                    gnt   <= 4'b0001 << winner;
                    busy  <= 1'b1;
                    cnt   <= RELOAD;
                end else begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - ONE;
            end
        end
    end

    assign bus.sel  = sel;
    assign bus.gnt  = gnt;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.y    = busy ? bus.din[sel] : 1'b0;

endmodule
